// File: rtl/decode_scoreboard.sv
// Decode-stage scoreboard: per-register in-flight write counters gate issue on
// RAW / WAW-depth hazards, and a small FSM holds fetch across control transfers.
module decode_scoreboard #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned BR_TIMEOUT = 8
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET_N,
  input  logic                I_LOCK,
  input  logic                I_IssueValid,
  input  logic                I_Src1Used,
  input  logic [IDX_W-1:0]    I_Src1Idx,
  input  logic                I_Src2Used,
  input  logic [IDX_W-1:0]    I_Src2Idx,
  input  logic                I_DestUsed,
  input  logic [IDX_W-1:0]    I_DestIdx,
  input  logic                I_IsBranch,
  input  logic                I_WbValid,
  input  logic [IDX_W-1:0]    I_WbIdx,
  input  logic                I_BranchResolved,
  output logic                O_Issue,
  output logic                O_DepStall,
  output logic                O_BranchStall,
  output logic [NUM_REGS-1:0] O_PendingMask,
  output logic [1:0]          O_Error
);

  localparam int unsigned TO_W = $clog2(BR_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BR_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BR_WAIT  = 2'd1;
  localparam logic [1:0] S_BR_DRAIN = 2'd2;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]      state, state_nxt;
  logic [TO_W-1:0] tcnt, tcnt_nxt;
  logic [1:0]      err_q;
  logic            uflow, to_hit;

  logic [CNT_W-1:0] src1_cnt, src2_cnt, dest_cnt;
  logic src1_busy, src2_busy, waw_full, hazard, cand;

  // Hazard detection; a retire of the last pending write frees the register this cycle
  always_comb begin
    src1_cnt  = cnt[I_Src1Idx];
    src2_cnt  = cnt[I_Src2Idx];
    dest_cnt  = cnt[I_DestIdx];
    src1_busy = (src1_cnt != '0) &&
                !(I_WbValid && (I_WbIdx == I_Src1Idx) && (src1_cnt == CNT_ONE));
    src2_busy = (src2_cnt != '0) &&
                !(I_WbValid && (I_WbIdx == I_Src2Idx) && (src2_cnt == CNT_ONE));
    waw_full  = I_DestUsed && (dest_cnt == CNT_MAX) &&
                !(I_WbValid && (I_WbIdx == I_DestIdx));
    hazard    = (I_Src1Used && src1_busy) || (I_Src2Used && src2_busy) || waw_full;
  end

  // Reset gating keeps every output low while I_RESET_N is asserted
  assign cand          = I_RESET_N && I_LOCK && I_IssueValid && (state == S_IDLE);
  assign O_Issue       = cand && !hazard;
  assign O_DepStall    = cand && hazard;
  assign O_BranchStall = I_RESET_N && ((state != S_IDLE) || (O_Issue && I_IsBranch));
  assign O_Error       = err_q;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      O_PendingMask[i] = |cnt[i];
    end
  end

  // Pending-write counters; retire at zero is flagged rather than wrapped
  always_comb begin
    cnt_nxt = cnt;
    uflow   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (I_WbValid && (I_WbIdx == IDX_W'(i)) && (cnt[i] == '0)) begin
        uflow = 1'b1;
      end else if (O_Issue && I_DestUsed && (I_DestIdx == IDX_W'(i))) begin
        if (!(I_WbValid && (I_WbIdx == IDX_W'(i)))) cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (I_WbValid && (I_WbIdx == IDX_W'(i))) begin
        cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
    end
  end

  // Branch sequencing; everything holds while I_LOCK is low
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    to_hit    = 1'b0;
    if (I_LOCK) begin
      case (state)
        S_IDLE: begin
          if (O_Issue && I_IsBranch) state_nxt = S_BR_WAIT;
        end
        S_BR_WAIT: begin
          if (I_BranchResolved) begin
            state_nxt = S_BR_DRAIN;
          end else if (tcnt == TO_LAST) begin
            state_nxt = S_BR_DRAIN;
            to_hit    = 1'b1;
          end else begin
            tcnt_nxt = tcnt + TO_W'(1);
          end
        end
        S_BR_DRAIN: begin
          state_nxt = S_IDLE;
          tcnt_nxt  = '0;
        end
        default: begin
          state_nxt = S_IDLE;
          tcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state <= S_IDLE;
      tcnt  <= '0;
      cnt   <= '0;
      err_q <= 2'b00;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_q | {to_hit, uflow};
    end
  end

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
- Dependency and branch-stall controller for the decode stage.
- Tracks in-flight writes per scalar register with small counters; a single valid bit is not enough.
- Gates instruction issue on RAW and WAW-depth hazards, with a same-cycle writeback bypass.
- Sequences the fetch stall around control transfers until execute resolves them.
- Sits between decode (issue candidates) and writeback (retire); drives stall signals back to fetch and decode.

Parameters:
- NUM_REGS, 16, number of tracked scalar registers (R0-R15).
- IDX_W, 4, register index width.
- CNT_W, 2, pending-write counter width; max in-flight writes per register = 2^CNT_W-1.
- BR_TIMEOUT, 8, max cycles in BR_WAIT before a forced exit.

Ports:
- I_CLOCK  in  1  clock, all state updates on rising edge.
- I_RESET_N  in  1  asynchronous active-low reset.
- I_LOCK  in  1  pipeline enable; 0 blocks issue and freezes the FSM.
- I_IssueValid  in  1  decode presents a candidate instruction.
- I_Src1Used  in  1  candidate reads Src1.
- I_Src1Idx  in  IDX_W  Src1 register.
- I_Src2Used  in  1  candidate reads Src2.
- I_Src2Idx  in  IDX_W  Src2 register.
- I_DestUsed  in  1  candidate writes a register.
- I_DestIdx  in  IDX_W  destination register.
- I_IsBranch  in  1  candidate is BR*/JMP/JSR/JSRR.
- I_WbValid  in  1  writeback retiring a register write this cycle.
- I_WbIdx  in  IDX_W  retiring register.
- I_BranchResolved  in  1  execute has resolved the outstanding control transfer.
- O_Issue  out  1  candidate accepted this cycle.
- O_DepStall  out  1  candidate held for a data hazard (treated as NOP downstream).
- O_BranchStall  out  1  fetch must hold.
- O_PendingMask  out  NUM_REGS  bit i = counter i nonzero (registered).
- O_Error  out  2  sticky: [0] retire with zero count, [1] branch timeout.

Behaviour:
- Reset: I_RESET_N low immediately clears all counters, FSM=IDLE, timeout counter=0, O_Error=0. While in reset, all outputs are 0.
- busy(r) = cnt[r]!=0 and not (I_WbValid and I_WbIdx==r and cnt[r]==1). This is the same-cycle writeback bypass.
- Hazard:
  - RAW: (I_Src1Used & busy(Src1)) | (I_Src2Used & busy(Src2)).
  - WAW depth: I_DestUsed & cnt[Dest]==max & not(I_WbValid & I_WbIdx==Dest).
- Combinational outputs:
  - O_Issue = I_LOCK & I_IssueValid & state==IDLE & !hazard.
  - O_DepStall = I_LOCK & I_IssueValid & state==IDLE & hazard.
  - O_BranchStall = (state!=IDLE) | (O_Issue & I_IsBranch).
- Counter update each edge, independent of I_LOCK:
  - inc = O_Issue & I_DestUsed & I_DestIdx==r.
  - dec = I_WbValid & I_WbIdx==r.
  - inc and dec together: counter unchanged.
  - dec at 0: counter stays 0, O_Error[0] set.
  - Increment at max cannot occur, because the hazard blocks it.
- R0 is tracked like any other register; there is no hardwired zero.
- FSM:
  - IDLE -> BR_WAIT on O_Issue & I_IsBranch.
  - BR_WAIT: when I_LOCK=1, timeout counter increments each cycle.
    - I_BranchResolved -> BR_DRAIN.
    - Timeout counter reaches BR_TIMEOUT -> set O_Error[1], go to BR_DRAIN.
    - Resolve wins over timeout when both occur in the same cycle (no error).
  - BR_DRAIN: exactly one cycle (fetch redirect bubble) -> IDLE; timeout counter cleared.
  - I_BranchResolved in IDLE or BR_DRAIN is ignored.
  - I_LOCK=0: FSM and timeout counter hold; writeback retirement continues.
- Reset asserted mid-BR_WAIT or mid-DRAIN returns to IDLE asynchronously. Pending counts are lost; the pipeline must be flushed alongside.
- O_PendingMask reflects post-edge counter state.

Test Plan:
- Reset/idle: hold I_RESET_N=0 3 cycles, release, I_IssueValid=0 -> O_PendingMask=0, all outputs 0, O_Error=0.
- RAW + bypass:
  - Issue dest R3 at t -> mask bit3=1.
  - At t+1 candidate Src1=R3 -> O_DepStall=1, O_Issue=0.
  - At t+3 I_WbValid/R3 -> O_Issue=1 that same cycle, mask bit3=0 after edge.
- WAW depth:
  - Issue dest R5 three times -> cnt=3; fourth dest R5 -> O_DepStall=1.
  - Assert wb R5 same cycle -> O_Issue=1, cnt stays 3.
- Branch sequencing:
  - Branch issued at t -> O_BranchStall=1 from t.
  - I_BranchResolved at t+4 -> DRAIN at t+5, IDLE at t+6, O_BranchStall=0 at t+6.
  - Non-branch candidate at t+2 -> O_Issue=0, O_DepStall=0.
- Timeout/lock:
  - Branch with no resolve and I_LOCK=1 -> O_Error[1]=1 after 8 BR_WAIT cycles, IDLE one cycle later.
  - Repeat with I_LOCK=0 for 5 cycles mid-wait -> expiry delayed by 5.
- Underflow + async reset: wb R9 with cnt=0 -> O_Error=2'b01, cnt 0. Drop I_RESET_N mid-BR_WAIT between edges -> outputs 0 and O_Error cleared immediately.
